// File: rtl/tdl_pkg.sv
// ---------------------------------------------------------------------------
// tdl_pkg
//   Shared definitions for the TDL (timing distribution link) transmit and
//   receive paths: 8b/10b control characters, the CRC-8 used to protect
//   each message frame, and the transmit framer state encoding.
//
//   Contents:
//     K28_5, K27_7, D16_2        8b/10b characters (comma, SOF, idle filler)
//     CRC8_POLY, CRC8_INIT       CRC-8 x^8+x^2+x+1, MSB first, no reflection
//     FRAME_WORDS                words per message frame
//     IDLE_WORD, CHARISK_*       convenience encodings of the 16-bit lane
//     tdl_tx_state_t             transmit framer FSM states
//     crc8_byte()                one-byte CRC-8 update step
// ---------------------------------------------------------------------------
package tdl_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [7:0] K27_7     = 8'hFB;
  localparam logic [7:0] D16_2     = 8'h50;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;
  localparam int         FRAME_WORDS = 4;

  // Comma idle: K28.5 in byte 0 (sent first), D16.2 filler in byte 1.
  localparam logic [15:0] IDLE_WORD   = {D16_2, K28_5};
  // Byte 0 is a control character, byte 1 is data.
  localparam logic [1:0]  CHARISK_K0  = 2'b01;
  // Both bytes are data.
  localparam logic [1:0]  CHARISK_D   = 2'b00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOF  = 3'd1,
    D0   = 3'd2,
    D1   = 3'd3,
    CRC  = 3'd4
  } tdl_tx_state_t;

  // One byte of CRC-8 (poly 0x07), MSB first. Shared with the receiver so
  // both ends of the link agree on the bit ordering.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc ^ data_byte;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/tdl_crc8.sv
// ---------------------------------------------------------------------------
// tdl_crc8
//   Combinational CRC-8 over one TDL message as it appears on the link:
//   msg_type, msg_data bytes 0..3 (least significant first), then seq.
//   Kept as a module so the receiver checks frames with the identical
//   byte ordering.
//
//   Ports:
//     msg_type  in   8   message type byte
//     msg_data  in  32   message payload
//     seq       in   8   frame sequence number
//     crc       out  8   CRC-8 of the six bytes, init 8'hFF, no final XOR
// ---------------------------------------------------------------------------
module tdl_crc8
  import tdl_pkg::*;
(
  input  logic [7:0]  msg_type,
  input  logic [31:0] msg_data,
  input  logic [7:0]  seq,
  output logic [7:0]  crc
);

  always_comb begin
    crc = CRC8_INIT;
    crc = crc8_byte(crc, msg_type);
    crc = crc8_byte(crc, msg_data[7:0]);
    crc = crc8_byte(crc, msg_data[15:8]);
    crc = crc8_byte(crc, msg_data[23:16]);
    crc = crc8_byte(crc, msg_data[31:24]);
    crc = crc8_byte(crc, seq);
  end

endmodule

// File: rtl/tdl_tx_framer.sv
// ---------------------------------------------------------------------------
// tdl_tx_framer
//   Transmit framer for one TDL channel. Drives the 16-bit GTH TX user
//   interface with K28.5 comma idles, interleaving four-word message frames:
//     W0 {msg_type, K27.7}   W1 data[15:0]   W2 data[31:16]   W3 {seq, crc}
//   At least MIN_IDLE idle words separate frames (and follow reset release).
//
//   Parameters:
//     MIN_IDLE   minimum idle words between frames, 1..15
//     SEQ_INIT   sequence number loaded at reset
//
//   Ports:
//     clk          in   1   TX user clock (txusrclk2), one word per cycle
//     reset_n      in   1   asynchronous active-low reset
//     tx_enable    in   1   allow new frames to be accepted
//     msg_valid    in   1   message request
//     msg_ready    out  1   message accepted on msg_valid && msg_ready
//     msg_type     in   8   message type byte
//     msg_data     in  32   message payload
//     txdata       out 16   word to the GTH, byte 0 = [7:0] sent first
//     txcharisk    out  2   per-byte K flag, bit 0 for [7:0]
//     frames_sent  out 32   completed frame count, wraps
// ---------------------------------------------------------------------------
module tdl_tx_framer
  import tdl_pkg::*;
#(
  parameter int         MIN_IDLE = 4,
  parameter logic [7:0] SEQ_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_enable,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  msg_type,
  input  logic [31:0] msg_data,
  output logic [15:0] txdata,
  output logic [1:0]  txcharisk,
  output logic [31:0] frames_sent
);

  localparam logic [3:0] MIN_IDLE_W = 4'(MIN_IDLE);

  // -------------------------------------------------------------------------
  // Reset release synchroniser: assertion is immediate, release is taken
  // through two flops so every state register leaves reset on the same edge.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       run;

  // NOTE: clocked state is always written with non-blocking (<=) so every
  // flop samples the pre-edge value of its inputs, matching the hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // -------------------------------------------------------------------------
  // State, counters and holding registers
  // -------------------------------------------------------------------------
  tdl_tx_state_t state, state_nxt;
  logic [3:0]    idle_cnt, idle_cnt_nxt;
  logic [7:0]    type_q;
  logic [31:0]   data_q;
  logic [7:0]    seq_q;
  logic [7:0]    crc_q;
  logic [7:0]    crc_calc;
  logic [15:0]   txdata_nxt;
  logic [1:0]    txcharisk_nxt;
  logic          ready_nxt;
  logic          accept;

  assign accept = msg_valid && msg_ready;

  // -------------------------------------------------------------------------
  // Next-state and output-word decode
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    idle_cnt_nxt  = idle_cnt;
    txdata_nxt    = IDLE_WORD;
    txcharisk_nxt = CHARISK_K0;

    case (state)
      IDLE: begin
        if (idle_cnt < MIN_IDLE_W) idle_cnt_nxt = idle_cnt + 4'd1;
        if (accept)                state_nxt    = SOF;
      end
      SOF: begin
        txdata_nxt    = {type_q, K27_7};
        txcharisk_nxt = CHARISK_K0;
        state_nxt     = D0;
      end
      D0: begin
        txdata_nxt    = data_q[15:0];
        txcharisk_nxt = CHARISK_D;
        state_nxt     = D1;
      end
      D1: begin
        txdata_nxt    = data_q[31:16];
        txcharisk_nxt = CHARISK_D;
        state_nxt     = CRC;
      end
      CRC: begin
        txdata_nxt    = {seq_q, crc_q};
        txcharisk_nxt = CHARISK_D;
        state_nxt     = IDLE;
        idle_cnt_nxt  = '0;
      end
      default: begin
        state_nxt    = IDLE;
        idle_cnt_nxt = '0;
      end
    endcase

    // idle_cnt counts idles already on the wire. The accepting edge itself
    // drives one more idle before W0, so ready opens one count early; that
    // makes the gap exactly MIN_IDLE words when msg_valid is held high.
    ready_nxt = tx_enable && (state_nxt == IDLE) &&
                (({1'b0, idle_cnt_nxt} + 5'd1) >= {1'b0, MIN_IDLE_W});
  end

  // -------------------------------------------------------------------------
  // FSM, idle counter and registered outputs. Held in their reset values
  // until the synchronised release arrives.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      msg_ready <= 1'b0;
      txdata    <= IDLE_WORD;
      txcharisk <= CHARISK_K0;
    end else if (!run) begin
      state     <= IDLE;
      idle_cnt  <= '0;
      msg_ready <= 1'b0;
      txdata    <= IDLE_WORD;
      txcharisk <= CHARISK_K0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_cnt_nxt;
      msg_ready <= ready_nxt;
      txdata    <= txdata_nxt;
      txcharisk <= txcharisk_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Message capture: inputs are free to change once the handshake is done.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      type_q <= msg_type;
      data_q <= msg_data;
    end
  end

  // -------------------------------------------------------------------------
  // CRC over the captured message. seq_q is stable until W3 leaves, so the
  // value is registered in D0 and only used while in CRC.
  // -------------------------------------------------------------------------
  tdl_crc8 u_crc8 (
    .msg_type (type_q),
    .msg_data (data_q),
    .seq      (seq_q),
    .crc      (crc_calc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          crc_q <= '0;
    else if (state == D0)  crc_q <= crc_calc;
  end

  // -------------------------------------------------------------------------
  // Sequence number and frame counter advance on the edge that drives W3.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q       <= SEQ_INIT;
      frames_sent <= '0;
    end else if (run && state == CRC) begin
      seq_q       <= seq_q + 8'd1;
      frames_sent <= frames_sent + 32'd1;
    end
  end

endmodule

// File: tb/tb_tdl_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_tdl_tx_framer
//   Self-checking bench for tdl_tx_framer. Accepted messages are pushed to a
//   scoreboard queue; a monitor parses frames off txdata/txcharisk, pops the
//   expected entry and compares all four words, the CRC (from an independent
//   bit-serial model), the inter-frame idle gap and frames_sent.
// ---------------------------------------------------------------------------
module tb_tdl_tx_framer;

  localparam int         MIN_IDLE = 4;
  localparam logic [7:0] SEQ_INIT = 8'h00;

  logic        clk;
  logic        reset_n;
  logic        tx_enable;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_type;
  logic [31:0] msg_data;
  logic [15:0] txdata;
  logic [1:0]  txcharisk;
  logic [31:0] frames_sent;

  tdl_tx_framer #(
    .MIN_IDLE (MIN_IDLE),
    .SEQ_INIT (SEQ_INIT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_enable   (tx_enable),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_type    (msg_type),
    .msg_data    (msg_data),
    .txdata      (txdata),
    .txcharisk   (txcharisk),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0]  mtype;
    logic [31:0] data;
    logic [7:0]  seq;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_seq  = SEQ_INIT;
  bit         gap_chk  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bit-serial LFSR form of CRC-8 (poly 0x07, init FF), fed MSB first.
  function automatic logic [7:0] model_crc(input exp_t e);
    logic [7:0] b [6];
    logic [7:0] c;
    logic       fb;
    b[0] = e.mtype;
    b[1] = e.data[7:0];
    b[2] = e.data[15:8];
    b[3] = e.data[23:16];
    b[4] = e.data[31:24];
    b[5] = e.seq;
    c = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[k][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  // -------------------------------------------------------------------------
  initial begin
    logic        in_frame;
    int          widx;
    int          idle_run;
    int          frames_model;
    logic [15:0] fw [4];
    logic [1:0]  fk [4];
    exp_t        e;
    in_frame     = 1'b0;
    widx         = 0;
    idle_run     = 0;
    frames_model = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame     = 1'b0;
        widx         = 0;
        idle_run     = 0;
        frames_model = 0;
      end else if (in_frame) begin
        fw[widx] = txdata;
        fk[widx] = txcharisk;
        widx++;
        if (widx == 4) begin
          if (sb.size() == 0) begin
            check("unexpected_frame", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            check("w0", 32'({fk[0], fw[0]}), 32'({2'b01, e.mtype, 8'hFB}));
            check("w1", 32'({fk[1], fw[1]}), 32'({2'b00, e.data[15:0]}));
            check("w2", 32'({fk[2], fw[2]}), 32'({2'b00, e.data[31:16]}));
            check("w3", 32'({fk[3], fw[3]}), 32'({2'b00, e.seq, model_crc(e)}));
          end
          frames_model++;
          check("frames_sent", frames_sent, 32'(frames_model));
          in_frame = 1'b0;
          idle_run = 0;
        end
      end else if (txcharisk == 2'b01 && txdata[7:0] == 8'hFB) begin
        if (gap_chk) check("idle_gap", 32'(idle_run), 32'(MIN_IDLE));
        fw[0]    = txdata;
        fk[0]    = txcharisk;
        widx     = 1;
        in_frame = 1'b1;
      end else begin
        check("idle_word", 32'({txcharisk, txdata}), 32'({2'b01, 16'h50BC}));
        idle_run++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver helpers
  // -------------------------------------------------------------------------
  // Present a message and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] t, input logic [31:0] d);
    int   waited;
    exp_t e;
    waited    = 0;
    msg_valid = 1'b1;
    msg_type  = t;
    msg_data  = d;
    @(negedge clk);
    while (!msg_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!msg_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      e.mtype = t;
      e.data  = d;
      e.seq   = exp_seq;
      sb.push_back(e);
      exp_seq = exp_seq + 8'd1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    sb.delete();
    exp_seq = SEQ_INIT;
    reset_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int   k;
    exp_t e;
    reset_n   = 1'b0;
    tx_enable = 1'b0;
    msg_valid = 1'b0;
    msg_type  = 8'h00;
    msg_data  = 32'h0;

    // Reset then idle
    repeat (5) @(negedge clk);
    check("rst_txdata", 32'(txdata), 32'h50BC);
    check("rst_charisk", 32'(txcharisk), 32'h1);
    check("rst_ready", 32'(msg_ready), 32'h0);
    check("rst_frames", frames_sent, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("disabled_ready", 32'(msg_ready), 32'h0);
      check("disabled_frames", frames_sent, 32'h0);
    end

    // Single frame
    tx_enable = 1'b1;
    send(8'h12, 32'hDEADBEEF);
    msg_valid = 1'b0;
    drain();
    check("single_frames", frames_sent, 32'd1);

    // Input stability: scramble the inputs right after the handshake
    send(8'hA5, 32'h01234567);
    msg_type  = 8'h00;
    msg_data  = 32'hFFFFFFFF;
    msg_valid = 1'b0;
    drain();

    // tx_enable drop during W1, with another request pending
    send(8'h3C, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    #1;
    tx_enable = 1'b0;
    msg_type  = 8'h77;
    msg_data  = 32'h55AA55AA;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("drop_ready", 32'(msg_ready), 32'h0);
    end
    check("drop_frames", frames_sent, 32'd3);
    tx_enable = 1'b1;
    send(8'h77, 32'h55AA55AA);
    msg_valid = 1'b0;
    drain();
    check("reenable_frames", frames_sent, 32'd4);

    // Mid-frame reset during W2
    send(8'h99, 32'h0BADF00D);
    msg_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_txdata", 32'(txdata), 32'h50BC);
    check("midrst_charisk", 32'(txcharisk), 32'h1);
    check("midrst_ready", 32'(msg_ready), 32'h0);
    check("midrst_frames", frames_sent, 32'h0);
    repeat (3) @(negedge clk);
    sb.delete();
    exp_seq   = SEQ_INIT;
    msg_valid = 1'b1;
    msg_type  = 8'h42;
    msg_data  = 32'h13579BDF;
    reset_n   = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (msg_ready) break;
    end
    // Acceptance happens on the rising edge after ready is first seen; that
    // edge must be at least synchroniser depth + MIN_IDLE edges after release.
    check("release_accept_edge", 32'((k + 1) >= (MIN_IDLE + 2)), 32'd1);
    if (msg_ready) begin
      e.mtype = 8'h42;
      e.data  = 32'h13579BDF;
      e.seq   = exp_seq;
      sb.push_back(e);
      exp_seq = exp_seq + 8'd1;
      @(posedge clk);
      #1;
    end else begin
      check("release_ready_timeout", 32'd0, 32'd1);
    end
    msg_valid = 1'b0;
    drain();
    check("postrst_frames", frames_sent, 32'd1);

    // Back-to-back: 300 frames, seq wraps, gaps exactly MIN_IDLE
    do_reset(3);
    for (int i = 0; i < 300; i++) begin
      send(8'(i) ^ 8'h5A, $urandom);
      if (i == 1) gap_chk = 1'b1;
    end
    msg_valid = 1'b0;
    drain();
    gap_chk = 1'b0;
    check("b2b_frames", frames_sent, 32'd300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdl_tx_framer.md
# tdl_tx_framer

Transmit-side framer for a TDL (timing distribution link) channel. It drives the 16-bit GTH TX user interface (txdata/txcharisk, 8b/10b enabled in the transceiver) with a continuous stream: K28.5 comma idles interleaved with fixed-length message frames. It is the far-end counterpart of the TDL receiver that asserts `link_status` and recovers the clock. One instance sits beside each transceiver channel, clocked by that channel's TX user clock.

## Interface
Parameters:
- MIN_IDLE, 4: minimum idle words between two frames, including the post-reset gap; legal range 1..15.
- SEQ_INIT, 8'h00: sequence number loaded at reset.

Ports:
- clk  input  1  TX user clock (txusrclk2), one 16-bit word per cycle.
- reset_n  input  1  asynchronous, active-low reset.
- tx_enable  input  1  high: frames may be accepted; low: idles only.
- msg_valid  input  1  message request.
- msg_ready  output  1  framer accepts the message on `msg_valid && msg_ready`.
- msg_type  input  8  message type byte.
- msg_data  input  32  message payload.
- txdata  output  16  word to the GTH; byte 0 = [7:0] is sent first.
- txcharisk  output  2  per-byte K flag; bit 0 is for [7:0].
- frames_sent  output  32  count of completed frames; wraps.

## Operation
- Idle word: txdata = 16'h50BC (K28.5, D16.2), txcharisk = 2'b01.
- A frame is four words:
  - W0 = {msg_type, 8'hFB} (K27.7 SOF), txcharisk = 2'b01.
  - W1 = msg_data[15:0], txcharisk = 2'b00.
  - W2 = msg_data[31:16], txcharisk = 2'b00.
  - W3 = {seq, crc}, txcharisk = 2'b00.
- CRC is CRC-8, polynomial x^8+x^2+x+1 (0x07), init 8'hFF, no reflection, no final XOR. Input bytes, in order: msg_type, data[7:0], data[15:8], data[23:16], data[31:24], seq.
- seq is 8 bits. It increments after each W3 and wraps 8'hFF -> 8'h00.
- FSM states:
  - IDLE: emits idles and counts idle words sent, saturating at MIN_IDLE. Go to SOF on handshake.
  - SOF -> D0 -> D1 -> CRC -> IDLE, unconditionally, one word per state. The idle counter clears on entry to IDLE.
- msg_ready = state==IDLE && idle_cnt>=MIN_IDLE && tx_enable. It is registered and is not combinationally dependent on msg_valid.
- Inputs are captured into holding registers on the handshake. They may change afterwards without affecting the frame.
- tx_enable falling mid-frame: the frame completes normally, and no new frame is accepted.
- msg_valid held high continuously: frames are separated by exactly MIN_IDLE idles.
- frames_sent increments on the cycle W3 is driven; it wraps 32'hFFFFFFFF -> 0.

## Timing
- All outputs are registered.
- Handshake at rising edge N -> W0 on txdata after edge N+1; W1, W2 and W3 follow on consecutive cycles.
- msg_ready drops after edge N and stays low for the remaining frame words plus the MIN_IDLE gap.
- Back-to-back throughput: one frame per 4+MIN_IDLE cycles.
- Reset (asynchronous assert, any state, including mid-frame):
  - txdata = 16'h50BC, txcharisk = 2'b01.
  - msg_ready = 0, frames_sent = 0, seq = SEQ_INIT, state = IDLE, idle_cnt = 0.
  - A truncated frame is simply abandoned; the receiver discards it on CRC or length failure.
- Release from reset:
  - Release is synchronised internally with a two-flop release.
  - The first msg_ready can occur no earlier than MIN_IDLE cycles after release.

## Structure
- Package `tdl_pkg` holds:
  - constants K28_5 = 8'hBC, K27_7 = 8'hFB, D16_2 = 8'h50, CRC8_POLY = 8'h07, CRC8_INIT = 8'hFF, FRAME_WORDS = 4;
  - the FSM enum `tdl_tx_state_t` (IDLE, SOF, D0, D1, CRC);
  - the function `crc8_byte(crc, byte)`, reused by the receiver.
- CRC is computed combinationally over the captured registers during SOF/D0 and registered for the CRC state. No sub-module is needed. An optional `tdl_crc8` wrapper is permitted if the receiver shares it.

## Test plan
- Reset then idle:
  - reset_n low for 5 cycles, tx_enable=0, 100 cycles run -> every word is 16'h50BC/2'b01, msg_ready=0, frames_sent=0.
- Single frame:
  - tx_enable=1, wait for ready, send type 8'h12, data 32'hDEADBEEF.
  - Expect 16'h12FB/01, 16'hBEEF/00, 16'hDEAD/00, then {8'h00, crc}/00, with crc equal to the bench `crc8_byte` model.
  - frames_sent=1.
- Back-to-back:
  - msg_valid held high for 300 frames with MIN_IDLE=4 -> exactly 4 idles between frames, seq runs 0..255 then wraps to 0..43, frames_sent=300.
- tx_enable drop:
  - deassert during W1 -> W2 and W3 still emitted, then idles only, msg_ready stays 0 until re-enabled.
- Mid-frame reset:
  - assert reset_n low during W2 -> the next sampled word is 16'h50BC/01, seq=0.
  - The first ready comes ≥MIN_IDLE cycles after release plus synchroniser delay.
- Input stability:
  - change msg_data one cycle after the handshake -> the transmitted W1/W2 and CRC reflect the captured value.
